ram_test_master: RTL and testbench

- Avalon-MM master engine that drives the on-chip 32-bit single-port RAM slave from the fabric side.
- Fills a word range with a deterministic pattern, reads the range back, and compares each word against the expected value.
- Used for power-on memory test and for preloading scratch buffers before the CPU runs.
- Sits between a small control register block and the RAM's s1/s2 slave port.

---
 rtl/ram_test_master.sv | 239 +++++++++++++++++++++++
 tb/tb_ram_test_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_test_master.sv
// Avalon-MM fill/verify engine for the on-chip 32-bit single-port RAM.
// Define MEMTEST_LFSR_EN to use a Galois LFSR pattern instead of seed + index.
module ram_test_master #(
    parameter int ADDR_W       = 11,
    parameter int MEM_WORDS    = 1280,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_flag,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_e;

    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

`ifdef MEMTEST_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] pat_first(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] p);
        return {1'b0, p[31:1]} ^ (p[0] ? LFSR_TAPS : 32'h0);
    endfunction
`else
    function automatic logic [31:0] pat_first(input logic [31:0] s);
        return s;
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] p);
        return p + 32'd1;
    endfunction
`endif

    state_e            state_q, state_d;
    logic              wr_then_rd_q, wr_then_rd_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       seed_q, seed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [31:0]       pat_q, pat_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic              done_q;
    logic              clken_q;

    logic [READ_LATENCY-1:0] pipe_v_q;
    logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
    logic [31:0]             pipe_exp_q  [READ_LATENCY];

    logic              push;
    logic              clear_err;
    logic              cs;
    logic              wr;
    logic              pipe_busy;
    logic              mismatch;
    logic              last_beat;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] base_norm;

    // One conditional subtract suffices because 2**ADDR_W < 2*MEM_WORDS.
    assign base_norm = ({1'b0, base_addr} >= CNT_W'(MEM_WORDS)) ?
                       base_addr - ADDR_W'(MEM_WORDS) : base_addr;
    assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign last_beat = (idx_q + 1'b1) == count_q;
    assign mismatch  = pipe_v_q[READ_LATENCY-1] &&
                       (avm_readdata != pipe_exp_q[READ_LATENCY-1]);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d      = state_q;
        wr_then_rd_d = wr_then_rd_q;
        base_d       = base_q;
        count_d      = count_q;
        seed_d       = seed_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        pat_d        = pat_q;
        push         = 1'b0;
        clear_err    = 1'b0;
        cs           = 1'b0;
        wr           = 1'b0;
        pipe_busy    = 1'b0;
        for (int k = 0; k < READ_LATENCY - 1; k++) begin
            pipe_busy = pipe_busy | pipe_v_q[k];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_then_rd_d = mode[1];
                    base_d       = base_norm;
                    count_d      = word_count;
                    seed_d       = pat_first(seed);
                    addr_d       = base_norm;
                    idx_d        = '0;
                    pat_d        = pat_first(seed);
                    clear_err    = 1'b1;
                    if (word_count == '0)  state_d = FIN;
                    else if (mode == 2'b01) state_d = RD;
                    else                    state_d = WR;
                end
            end
            WR: begin
                cs = 1'b1;
                wr = 1'b1;
                if (!avm_waitrequest) begin
                    if (last_beat) begin
                        // Rewind the pointer so the verify pass starts from index 0.
                        addr_d  = base_q;
                        idx_d   = '0;
                        pat_d   = seed_q;
                        state_d = wr_then_rd_q ? RD : FIN;
                    end else begin
                        addr_d = next_addr;
                        idx_d  = idx_q + 1'b1;
                        pat_d  = pat_next(pat_q);
                    end
                end
            end
            RD: begin
                cs = 1'b1;
                if (!avm_waitrequest) begin
                    push = 1'b1;
                    if (last_beat) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = next_addr;
                        idx_d  = idx_q + 1'b1;
                        pat_d  = pat_next(pat_q);
                    end
                end
            end
            DRAIN: begin
                // Only the exiting stage may still be valid once this edge empties the pipe.
                if (!pipe_busy) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_err_d = first_err_q;
        if (clear_err) begin
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            first_err_d = '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            err_flag_d = 1'b1;
            if (!err_flag_q) first_err_d = pipe_addr_q[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_then_rd_q <= 1'b0;
            base_q       <= '0;
            count_q      <= '0;
            seed_q       <= '0;
            addr_q       <= '0;
            idx_q        <= '0;
            pat_q        <= '0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
            first_err_q  <= '0;
            done_q       <= 1'b0;
            clken_q      <= 1'b0;
            pipe_v_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            wr_then_rd_q <= wr_then_rd_d;
            base_q       <= base_d;
            count_q      <= count_d;
            seed_q       <= seed_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            pat_q        <= pat_d;
            err_cnt_q    <= err_cnt_d;
            err_flag_q   <= err_flag_d;
            first_err_q  <= first_err_d;
            done_q       <= (state_q == FIN);
            clken_q      <= 1'b1;
            pipe_v_q[0]  <= push;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_v_q[k] <= pipe_v_q[k-1];
            end
        end
    end

    // NOTE: the pipeline payload has no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        pipe_addr_q[0] <= addr_q;
        pipe_exp_q[0]  <= pat_q;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_addr_q[k] <= pipe_addr_q[k-1];
            pipe_exp_q[k]  <= pipe_exp_q[k-1];
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err_count      = err_cnt_q;
    assign err_flag       = err_flag_q;
    assign first_err_addr = first_err_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs;
    assign avm_write      = wr;
    assign avm_byteenable = 4'hF;
    assign avm_writedata  = pat_q;
    assign avm_clken      = clken_q;

endmodule

// File: tb/tb_ram_test_master.sv
// Self-checking bench for ram_test_master: RAM slave model, beat scoreboard and run checks.
module tb_ram_test_master;

    localparam int ADDR_W    = 11;
    localparam int MEM_WORDS = 1280;
    localparam int RL        = 1;
    localparam int ERR_W     = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       seed;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic              err_flag;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic              avm_clken;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    int checks   = 0;
    int failures = 0;

    ram_test_master #(
        .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .word_count(word_count), .seed(seed),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .err_flag(err_flag),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM slave with backdoor access for clearing and corrupting words.
    logic [31:0] ram [MEM_WORDS];
    logic        bd_clear = 1'b0;
    logic        bd_we    = 1'b0;
    int          bd_addr  = 0;
    logic [31:0] bd_data  = '0;

    always @(posedge clk) begin
        if (bd_clear) begin
            for (int i = 0; i < MEM_WORDS; i++) ram[i] <= '0;
        end else if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (reset_n && avm_chipselect && !avm_waitrequest &&
                     int'(avm_address) < MEM_WORDS) begin
            if (avm_write) ram[avm_address] <= avm_writedata;
            else           avm_readdata     <= ram[avm_address];
        end
    end

    bit rand_wait = 1'b0;
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    // Reference model: what the RAM must hold, and the bus beats the master must issue.
    typedef struct {
        logic        wr;
        int          addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q [$];
    logic [31:0] model_mem [MEM_WORDS];

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && avm_chipselect) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(avm_address), 32'hFFFF_FFFF);
                end else begin
                    check("beat_wr", 32'(avm_write), 32'(exp_q[0].wr));
                    check("beat_addr", 32'(avm_address), 32'(exp_q[0].addr));
                    if (exp_q[0].wr) check("beat_data", avm_writedata, exp_q[0].data);
                    if (!avm_waitrequest) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic plan(input logic [1:0] m, input int base, input int cnt, input logic [31:0] sd,
                        input int wr_limit, output int exp_err, output int exp_first);
        int a;
        exp_err   = 0;
        exp_first = 0;
        if (m != 2'b01) begin
            for (int i = 0; i < cnt; i++) begin
                a = (base + i) % MEM_WORDS;
                exp_q.push_back('{1'b1, a, sd + 32'(i)});
                if (i < wr_limit) model_mem[a] = sd + 32'(i);
            end
        end
        if (m != 2'b00) begin
            for (int i = 0; i < cnt; i++) begin
                a = (base + i) % MEM_WORDS;
                exp_q.push_back('{1'b0, a, 32'h0});
                if (model_mem[a] != sd + 32'(i)) begin
                    if (exp_err == 0) exp_first = a;
                    exp_err++;
                end
            end
        end
        if (exp_err > 65535) exp_err = 65535;
    endtask

    task automatic backdoor(input int a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        model_mem[a] = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [1:0] m, input int base, input int cnt,
                           input logic [31:0] sd, input bit chk_lat, input int poke_c,
                           output int lat);
        int exp_err, exp_first, exp_lat, extra;
        bit found;
        plan(m, base, cnt, sd, cnt, exp_err, exp_first);
        if (cnt == 0)         exp_lat = 2;
        else if (m == 2'b00)  exp_lat = cnt + 2;
        else if (m == 2'b01)  exp_lat = cnt + RL + 2;
        else                  exp_lat = 2 * cnt + RL + 2;

        @(posedge clk);
        #1;
        start = 1'b1; mode = m; base_addr = ADDR_W'(base);
        word_count = (ADDR_W + 1)'(cnt); seed = sd;
        @(posedge clk);
        #1;
        // Inputs change after acceptance; the run must not notice.
        start = 1'b0; mode = ~m; base_addr = ~base_addr; word_count = ~word_count; seed = ~sd;

        lat   = -1;
        found = 1'b0;
        for (int c = 1; c <= 4000 && !found; c++) begin
            @(negedge clk);
            if (c == 1) check({name, ":busy_after_start"}, 32'(busy), 32'd1);
            if (c == poke_c) begin
                start = 1'b1; mode = 2'b10; word_count = 12'd20; base_addr = 11'd700;
            end else if (c == poke_c + 1) begin
                start = 1'b0;
            end
            if (done) begin
                found = 1'b1;
                lat   = c;
            end
        end
        start = 1'b0;
        if (!found) begin
            check({name, ":done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, ":busy_at_done"}, 32'(busy), 32'd0);
            if (chk_lat) check({name, ":latency"}, 32'(lat), 32'(exp_lat));
        end
        check({name, ":err_count"}, 32'(err_count), 32'(exp_err));
        check({name, ":err_flag"}, 32'(err_flag), 32'(exp_err != 0));
        check({name, ":first_err_addr"}, 32'(first_err_addr), 32'(exp_first));
        check({name, ":beats_left"}, 32'(exp_q.size()), 32'd0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({name, ":done_single"}, 32'(extra), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int lat, e1, e2;
        reset_n = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0;
        word_count = '0; seed = '0; avm_readdata = '0;
        bd_clear = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;

        #12;
        bd_clear = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_first_err", 32'(first_err_addr), 32'd0);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        check("rst_be", 32'(avm_byteenable), 32'hF);
        check("rst_clken", 32'(avm_clken), 32'd0);
        #15;
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("clken_after_rst", 32'(avm_clken), 32'd1);

        run_cmd("fill16", 2'b10, 0, 16, 32'h0000_1000, 1'b1, 0, lat);
        check("fill16:lat_literal", 32'(lat), 32'd35);
        check("fill16:ram0", ram[0], 32'h0000_1000);
        check("fill16:ram15", ram[15], 32'h0000_100F);

        backdoor(5, 32'hDEAD_BEEF);
        backdoor(9, 32'h0000_0000);
        run_cmd("verify_corrupt", 2'b01, 0, 16, 32'h0000_1000, 1'b1, 0, lat);
        check("verify_corrupt:err_literal", 32'(err_count), 32'd2);
        check("verify_corrupt:first_literal", 32'(first_err_addr), 32'd5);
        check("verify_corrupt:flag_literal", 32'(err_flag), 32'd1);

        run_cmd("wrap", 2'b10, 1278, 4, 32'h0, 1'b1, 0, lat);
        check("wrap:ram1278", ram[1278], 32'd0);
        check("wrap:ram1279", ram[1279], 32'd1);
        check("wrap:ram0", ram[0], 32'd2);
        check("wrap:ram1", ram[1], 32'd3);

        rand_wait = 1'b1;
        run_cmd("stall64", 2'b10, 200, 64, 32'hA5A5_0000, 1'b0, 0, lat);
        rand_wait = 1'b0;
        @(posedge clk);
        #1;
        check("stall64:ram263", ram[263], 32'hA5A5_003F);

        run_cmd("count0", 2'b10, 10, 0, 32'h1234_5678, 1'b1, 1, lat);
        check("count0:lat_literal", 32'(lat), 32'd2);

        run_cmd("mode11_datawrap", 2'b11, 500, 5, 32'hFFFF_FFFE, 1'b1, 0, lat);
        check("mode11:ram502", ram[502], 32'd0);

        run_cmd("write_only_poke", 2'b00, 600, 8, 32'h0BAD_0000, 1'b1, 3, lat);

        plan(2'b00, 300, 64, 32'h7000_0000, 7, e1, e2);
        @(posedge clk);
        #1;
        start = 1'b1; mode = 2'b10; base_addr = 11'd300; word_count = 12'd64; seed = 32'h7000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort:cs", 32'(avm_chipselect), 32'd0);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:write", 32'(avm_write), 32'd0);
        check("abort:clken", 32'(avm_clken), 32'd0);
        check("abort:addr", 32'(avm_address), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("abort:ram306", ram[306], 32'h7000_0006);
        check("abort:ram307", ram[307], 32'h0);
        run_cmd("abort_verify", 2'b01, 300, 7, 32'h7000_0000, 1'b1, 0, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
